cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Arbitrates two pipeline requesters onto one shared single-port memory bus with variable latency.
- Requester IF is instruction fetch, driven from the fetch stage PC.
- Requester LS is load/store, driven from the memory stage.
- Sits between cpu_pipeline_v2 and the unified memory. Provides:
  - request/grant/response handshakes with latched requests;
  - fixed LS priority with an anti-starvation counter for IF;
  - a per-access timeout that returns an error.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- STARVE_LIMIT, 3, maximum consecutive LS grants while IF is pending; range 1..15
- TIMEOUT, 16, maximum cycles with mem_req high before the access is aborted; range 2..255

Ports:
- sys_clk  in  1  clock, all logic on posedge
- sys_rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid, one-cycle pulse
- if_rdata  out  DATA_WIDTH  fetched instruction
- if_err  out  1  fetch timed out, qualified by if_rvalid
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_WIDTH  load/store address
- ls_wdata  in  DATA_WIDTH  store data
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load/store completion, one-cycle pulse
- ls_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- ls_err  out  1  load/store timed out, qualified by ls_rvalid
- mem_req  out  1  bus request, held until mem_ack or timeout
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_WIDTH  bus address
- mem_wdata  out  DATA_WIDTH  bus write data
- mem_ack  in  1  bus completion, one-cycle pulse
- mem_rdata  in  DATA_WIDTH  bus read data, valid with mem_ack

Behaviour:
- Reset (sys_rst_n=0 at posedge):
  - state=IDLE, all outputs 0, starve_cnt=0, tmo_cnt=0, owner=0.
  - Reset mid-access drops mem_req on the next cycle; no rvalid is produced for the aborted access.
- FSM states: IDLE, BUSY.
- IDLE:
  - gnt outputs are combinational and active only in IDLE.
  - Winner selection:
    - ls_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT): LS wins.
    - Otherwise, if if_req=1: IF wins.
  - Only one gnt is ever high in a cycle.
  - On a grant, at the posedge:
    - latch addr, we and wdata into mem_* registers (IF: we=0, wdata=0);
    - set owner;
    - clear tmo_cnt;
    - go to BUSY.
- starve_cnt update, on a grant:
  - LS granted while if_req=1: increment, saturating at 15.
  - IF granted: clear.
  - LS granted while if_req=0: clear.
- BUSY:
  - mem_req=1; mem_addr, mem_we and mem_wdata are stable from registers.
  - tmo_cnt increments every cycle.
  - mem_ack=1: capture mem_rdata and go to IDLE. Next cycle, the owner's rvalid=1, rdata=captured data (0 if we=1), err=0.
  - Otherwise, tmo_cnt==TIMEOUT-1: drop mem_req and go to IDLE. Next cycle, the owner's rvalid=1, err=1, rdata=0.
  - mem_ack in the same cycle as the timeout condition: ack wins.
  - mem_ack received while in IDLE is ignored.
- Latency and throughput:
  - gnt at cycle N; mem_req high from N+1; ack at cycle M≥N+1; rvalid at M+1.
  - Minimum grant-to-rvalid latency is 2 cycles.
  - The response cycle is also IDLE, so a new grant may coincide with rvalid. Back-to-back throughput is 1 access per 2 cycles with zero-wait memory.
- Requester rules:
  - A requester holds req with stable addr/data until it sees gnt.
  - Inputs after gnt are don't-care; the arbiter latched them.
  - A requester may deassert req before gnt (withdraw); no penalty.
- mem_we, mem_addr and mem_wdata hold their last values in IDLE; they are only meaningful with mem_req=1.

Test Plan:
- Single fetch, zero-wait:
  - Stimulus: if_req=1, if_addr=0x100; mem_ack one cycle after mem_req with rdata=0x00500093.
  - Required: if_gnt at N, mem_req N+1, if_rvalid at N+2 with if_rdata=0x00500093, if_err=0.
- Contention:
  - Stimulus: if_req and ls_req (store, addr 0x2000, wdata 0xDEADBEEF) both high in the same cycle.
  - Required: ls_gnt first with mem_we=1, mem_wdata=0xDEADBEEF; if_gnt at the first IDLE after ls_rvalid; ls_rdata=0.
- Starvation, STARVE_LIMIT=3:
  - Stimulus: if_req and ls_req held continuously, every mem_ack after 1 cycle.
  - Required: grant order LS,LS,LS,IF,LS,LS,LS,IF.
- Timeout, TIMEOUT=16:
  - Stimulus: LS load, mem_ack never asserted.
  - Required: mem_req high exactly 16 cycles; ls_rvalid=1 and ls_err=1 on the next cycle with ls_rdata=0; a subsequent fetch completes normally.
- Reset mid-access:
  - Stimulus: sys_rst_n=0 for 1 cycle while BUSY with mem_req=1; then mem_ack pulses.
  - Required: mem_req=0 after the reset edge; no rvalid; the stale ack is ignored; starve_cnt=0.
- Ack at timeout boundary:
  - Stimulus: mem_ack arrives in the cycle tmo_cnt==TIMEOUT-1.
  - Required: rvalid with err=0 and data captured from mem_rdata.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
// Shares one variable-latency, single-port memory bus between the instruction
// fetch (IF) and load/store (LS) requesters of the pipeline. LS has fixed
// priority, and a starvation counter forces an IF grant after STARVE_LIMIT
// consecutive LS grants taken while IF was waiting. Every bus access is bounded
// by TIMEOUT cycles; an expired access completes with an error response.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3,   // 1..15
    parameter int TIMEOUT      = 16   // 2..255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,

    // Instruction fetch requester
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,

    // Load/store requester
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,

    // Shared memory bus
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_t;

    // Parameters narrowed once to the widths of the counters they are compared with.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] STARVE_MAX = 4'd15;

    state_t     state;
    state_t     state_nxt;
    owner_t     owner;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;

    // Single-cycle decode of how the current access ends.
    logic       ack_done;
    logic       tmo_done;
    logic       any_gnt;

    // The bus request is simply "an access is outstanding".
    assign mem_req = (state == BUSY);
    assign any_gnt = if_gnt | ls_gnt;

    // State register.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: arbitration in IDLE, ack/timeout termination in BUSY.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_nxt = state;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        ack_done  = 1'b0;
        tmo_done  = 1'b0;

        unique case (state)
            IDLE: begin
                // Grants are suppressed while reset is asserted so no requester
                // believes it was accepted by an edge that is about to be discarded.
                if (sys_rst_n) begin
                    if (ls_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                        ls_gnt = 1'b1;
                    end else if (if_req) begin
                        if_gnt = 1'b1;
                    end
                    if (ls_gnt || if_gnt) begin
                        state_nxt = BUSY;
                    end
                end
            end

            BUSY: begin
                // An ack in the final allowed cycle still counts as a success.
                if (mem_ack) begin
                    ack_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant bookkeeping: latch the winner's request onto the bus and track
    // how long the IF requester has been passed over.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            owner      <= OWNER_IF;
            starve_cnt <= 4'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (any_gnt) begin
            if (ls_gnt) begin
                owner     <= OWNER_LS;
                mem_we    <= ls_we;
                mem_addr  <= ls_addr;
                mem_wdata <= ls_wdata;
            end else begin
                owner     <= OWNER_IF;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end

            // Only an LS grant that bypassed a waiting IF adds to the count.
            if (ls_gnt && if_req) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

    // Access timer: restarts on every grant, advances each cycle of the access.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tmo_cnt <= 8'd0;
        end else if (any_gnt) begin
            tmo_cnt <= 8'd0;
        end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Response path: one-cycle rvalid pulse to whichever requester owns the access.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
        end else begin
            // Response fields are cleared between pulses so stale data never lingers.
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;

            if (ack_done) begin
                if (owner == OWNER_LS) begin
                    ls_rvalid <= 1'b1;
                    // Stores return no data.
                    ls_rdata  <= mem_we ? '0 : mem_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_rdata;
                end
            end else if (tmo_done) begin
                if (owner == OWNER_LS) begin
                    ls_rvalid <= 1'b1;
                    ls_err    <= 1'b1;
                end else begin
                    if_rvalid <= 1'b1;
                    if_err    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter
// Directed bench for cpu_mem_arbiter. A behavioural memory answers bus requests
// after a programmable number of wait cycles; expected responses are queued per
// requester when a request is issued and compared when rvalid appears.
module tb_cpu_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          ls_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    resp_t if_q[$];
    resp_t ls_q[$];
    byte   grant_log[$];

    int checks    = 0;
    int failures  = 0;
    int ack_delay = 0;    // wait cycles before ack; negative means never ack
    bit force_ack = 1'b0; // stray ack regardless of bus state
    bit log_en    = 1'b0;

    cpu_mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(3),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_gnt   (ls_gnt),
        .ls_rvalid(ls_rvalid),
        .ls_rdata (ls_rdata),
        .ls_err   (ls_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    // Memory contents as a pure function of address.
    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: acks after ack_delay wait cycles of a held request.
    initial begin
        int busy;
        busy      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge sys_clk);
            #2;
            if (mem_req) busy++;
            else         busy = 0;
            if (force_ack || (mem_req && ack_delay >= 0 && busy == ack_delay + 1)) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_fn(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h0BAD_0BAD;
            end
        end
    end

    // Monitor: grant exclusivity, grant order log, scoreboard on responses.
    initial begin
        resp_t e;
        forever begin
            @(negedge sys_clk);
            if (if_gnt || ls_gnt) begin
                check("single_gnt", 64'(if_gnt & ls_gnt), 64'd0);
                if (log_en) grant_log.push_back(ls_gnt ? 8'h4C : 8'h49);
            end
            if (if_rvalid) begin
                if (if_q.size() == 0) begin
                    check("if_unexpected_rvalid", 64'(if_rvalid), 64'd0);
                end else begin
                    e = if_q.pop_front();
                    check("if_rdata", 64'(if_rdata), 64'(e.data));
                    check("if_err", 64'(if_err), 64'(e.err));
                end
            end
            if (ls_rvalid) begin
                if (ls_q.size() == 0) begin
                    check("ls_unexpected_rvalid", 64'(ls_rvalid), 64'd0);
                end else begin
                    e = ls_q.pop_front();
                    check("ls_rdata", 64'(ls_rdata), 64'(e.data));
                    check("ls_err", 64'(ls_err), 64'(e.err));
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "simulation time bound reached");
    end

    // One isolated access. Returns cycles to gnt, cycles from gnt to rvalid,
    // and the number of cycles mem_req was high.
    task automatic run_access(input bit is_ls, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input bit exp_err,
                              output int gw, output int rw, output int bw);
        bit    got;
        resp_t r;
        gw = 0; rw = 0; bw = 0;
        @(posedge sys_clk); #1;
        r.err  = exp_err;
        r.data = (exp_err || (is_ls && we)) ? '0 : rd_fn(addr);
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
            ls_q.push_back(r);
        end else begin
            if_req = 1'b1; if_addr = addr;
            if_q.push_back(r);
        end
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            got = is_ls ? ls_gnt : if_gnt;
            if (got) begin
                gw = i + 1;
                break;
            end
        end
        check("access_gnt_seen", 64'(got), 64'd1);
        @(posedge sys_clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (mem_req) bw++;
            got = is_ls ? ls_rvalid : if_rvalid;
            if (got) begin
                rw = i + 1;
                break;
            end
        end
        check("access_rvalid_seen", 64'(got), 64'd1);
    endtask

    // Both requesters held continuously until exp.len() grants have been made;
    // the grant order must match exp ("L" = load/store, "I" = fetch).
    task automatic run_starve(input string exp);
        resp_t r;
        int    n;
        n = exp.len();
        r.err = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (exp[k] == 8'h4C) begin
                r.data = rd_fn(32'h0000_3000);
                ls_q.push_back(r);
            end else begin
                r.data = rd_fn(32'h0000_0400);
                if_q.push_back(r);
            end
        end
        grant_log.delete();
        log_en = 1'b1;
        @(posedge sys_clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_3000;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        for (int i = 0; i < 300; i++) begin
            @(posedge sys_clk); #1;
            if (grant_log.size() >= n) break;
        end
        ls_req = 1'b0; if_req = 1'b0;
        log_en = 1'b0;
        repeat (10) @(posedge sys_clk);
        check("starve_grant_count", 64'(grant_log.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            check($sformatf("starve_order_%0d", k), 64'(grant_log[k]), 64'(exp[k]));
        end
    endtask

    initial begin
        int gw, rw, bw;
        sys_rst_n = 1'b0;
        if_req = 1'b1; if_addr = '0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;

        // Reset state, with both requests raised to show grants stay low.
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_if_gnt", 64'(if_gnt), 64'd0);
        check("rst_ls_gnt", 64'(ls_gnt), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
        check("rst_ls_rvalid", 64'(ls_rvalid), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        check("rst_ls_err", 64'(ls_err), 64'd0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;

        // Single zero-wait fetch: gnt N, mem_req N+1, rvalid N+2.
        ack_delay = 0;
        run_access(1'b0, 1'b0, 32'h0000_0100, '0, 1'b0, gw, rw, bw);
        check("fetch_gnt_wait", 64'(gw), 64'd1);
        check("fetch_rvalid_latency", 64'(rw), 64'd2);
        check("fetch_mem_req_cycles", 64'(bw), 64'd1);

        // Contention: a store and a fetch request in the same cycle.
        @(posedge sys_clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_2000; ls_wdata = 32'hDEAD_BEEF;
        ls_q.push_back('{data: '0, err: 1'b0});
        if_q.push_back('{data: rd_fn(32'h0000_0200), err: 1'b0});
        @(negedge sys_clk);
        check("cont_ls_gnt", 64'(ls_gnt), 64'd1);
        check("cont_if_gnt", 64'(if_gnt), 64'd0);
        @(posedge sys_clk); #1;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'hFFFF_FFFF; ls_wdata = '0;
        @(negedge sys_clk);
        check("cont_mem_req", 64'(mem_req), 64'd1);
        check("cont_mem_we", 64'(mem_we), 64'd1);
        check("cont_mem_addr", 64'(mem_addr), 64'h2000);
        check("cont_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("cont_if_gnt_busy", 64'(if_gnt), 64'd0);
        @(negedge sys_clk);
        check("cont_ls_rvalid", 64'(ls_rvalid), 64'd1);
        check("cont_if_gnt_resp_cycle", 64'(if_gnt), 64'd1);
        @(posedge sys_clk); #1;
        if_req = 1'b0;
        @(negedge sys_clk);
        check("cont_if_mem_addr", 64'(mem_addr), 64'h200);
        check("cont_if_mem_we", 64'(mem_we), 64'd0);
        check("cont_if_mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge sys_clk);
        check("cont_if_rvalid", 64'(if_rvalid), 64'd1);

        // Starvation with both requesters saturating the bus.
        ack_delay = 1;
        run_starve("LLLILLLI");

        // Timeout of a load that is never acknowledged, then a normal fetch.
        ack_delay = -1;
        run_access(1'b1, 1'b0, 32'h0000_5000, '0, 1'b1, gw, rw, bw);
        check("tmo_mem_req_cycles", 64'(bw), 64'(TIMEOUT));
        check("tmo_rvalid_latency", 64'(rw), 64'(TIMEOUT + 1));
        ack_delay = 2;
        run_access(1'b0, 1'b0, 32'h0000_0600, '0, 1'b0, gw, rw, bw);
        check("post_tmo_mem_req_cycles", 64'(bw), 64'd3);
        check("post_tmo_rvalid_latency", 64'(rw), 64'd4);

        // Reset in the middle of an access; the LS grant bumped starve_cnt first.
        ack_delay = -1;
        @(posedge sys_clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_8000;
        if_req = 1'b1; if_addr = 32'h0000_0900;
        @(negedge sys_clk);
        check("rstmid_ls_gnt", 64'(ls_gnt), 64'd1);
        @(posedge sys_clk); #1;
        ls_req = 1'b0; if_req = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("rstmid_mem_req_before", 64'(mem_req), 64'd1);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rstmid_mem_req_after", 64'(mem_req), 64'd0);
        check("rstmid_ls_rvalid", 64'(ls_rvalid), 64'd0);
        @(posedge sys_clk); #1;
        force_ack = 1'b1;
        @(posedge sys_clk); #1;
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("stale_ack_ls_rvalid", 64'(ls_rvalid), 64'd0);
            check("stale_ack_if_rvalid", 64'(if_rvalid), 64'd0);
            check("stale_ack_mem_req", 64'(mem_req), 64'd0);
        end
        ack_delay = 0;
        run_starve("LLLI");

        // Ack arriving in the last cycle before the timeout fires.
        ack_delay = TIMEOUT - 1;
        run_access(1'b1, 1'b0, 32'h0000_7000, '0, 1'b0, gw, rw, bw);
        check("edge_mem_req_cycles", 64'(bw), 64'(TIMEOUT));
        check("edge_rvalid_latency", 64'(rw), 64'(TIMEOUT + 1));

        repeat (5) @(posedge sys_clk);
        check("if_queue_drained", 64'(if_q.size()), 64'd0);
        check("ls_queue_drained", 64'(ls_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
